// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, master indices and timeout read data for mem_arbiter
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: one request/response memory port
//   master modport: requester side (drives rd_en, wr_en, addr, wdata; receives rdata, ack)
//   slave modport : responder side (the reverse)
interface mem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ack;

    modport master (output rd_en, wr_en, addr, wdata, input rdata, ack);
    modport slave  (input rd_en, wr_en, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: counts BUSY cycles without a memory ack and flags expiry
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : grant strobe, restarts the count
//   busy       : a transaction is in flight
//   mem_ack    : memory completion
//   expired    : combinational, high in the TIMEOUT_CYCLES-th unacked BUSY cycle
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic mem_ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (busy && !mem_ack)
            cnt <= cnt + 1'b1;

    // cnt holds the unacked cycles already completed, so the current one is number cnt+1
    assign expired = busy && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter onto one memory port, one transaction in flight
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : requester ports (mem_arb_if.slave), request held until ack
//   mem        : memory port (mem_arb_if.master), command latched at grant
//   err_o      : timeout flag, present only with MEM_ARB_TIMEOUT_EN defined
//                (also adds parameter TIMEOUT_CYCLES)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef MEM_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input logic       clk,
    input logic       rst_n,
    mem_arb_if.slave  m0,
    mem_arb_if.slave  m1,
    mem_arb_if.master mem
`ifdef MEM_ARB_TIMEOUT_EN
    , output logic    err_o
`endif
);

    state_t                state, state_nxt;
    logic                  last_grant, gnt, rd_q, wr_q;
    logic                  req0, req1, pick, grant, busy, expired, done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata;

    assign req0  = m0.rd_en | m0.wr_en;
    assign req1  = m1.rd_en | m1.wr_en;
    // a lone requester wins outright; on a tie the one not served last wins
    assign pick  = (req0 & req1) ? ~last_grant : req1;
    assign grant = state == ST_IDLE && (req0 || req1);
    assign busy  = state == ST_BUSY;
    assign done  = busy && (mem.ack || expired);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        state_nxt = grant ? ST_BUSY : done ? ST_IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            last_grant <= M1;
            gnt        <= M0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant) begin
            last_grant <= pick;
            gnt        <= pick;
            wr_q       <= pick ? m1.wr_en : m0.wr_en;
            // write wins when a master raises both strobes
            rd_q       <= pick ? m1.rd_en & ~m1.wr_en : m0.rd_en & ~m0.wr_en;
            addr_q     <= pick ? m1.addr : m0.addr;
            wdata_q    <= pick ? m1.wdata : m0.wdata;
        end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (grant),
        .busy    (busy),
        .mem_ack (mem.ack),
        .expired (expired)
    );
    assign err_o = expired;
`else
    assign expired = 1'b0;
`endif

    assign rdata = mem.ack ? mem.rdata : DATA_WIDTH'(TIMEOUT_DATA);

    assign mem.rd_en = busy & rd_q;
    assign mem.wr_en = busy & wr_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    assign m0.ack   = done && gnt == M0;
    assign m1.ack   = done && gnt == M1;
    assign m0.rdata = m0.ack ? rdata : '0;
    assign m1.rdata = m1.ack ? rdata : '0;

endmodule
